// File: rtl/control_ciclos_if.sv
// control_ciclos_if: bundle of the request/grant and result signals shared
// between the requesters (master side) and the cycle-counter arbiter (slave).
//   req[1:0]      requester i wants the counter
//   done[1:0]     requester i finished its measurement
//   limit         timeout threshold, sampled by the arbiter when loading
//   grant[1:0]    one-hot owner of the counter, 00 when none
//   busy          arbiter is loading, counting or reporting
//   count         live counter value
//   result        latched measured cycle count
//   result_id     requester that produced result
//   result_valid  one-cycle pulse qualifying result/result_id/timeout
//   timeout       last measurement ended by the limit
interface control_ciclos_if #(
  parameter int WIDTH = 8
);
  logic [1:0]       req;
  logic [1:0]       done;
  logic [WIDTH-1:0] limit;
  logic [1:0]       grant;
  logic             busy;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] result;
  logic             result_id;
  logic             result_valid;
  logic             timeout;

  modport master (
    output req, done, limit,
    input  grant, busy, count, result, result_id, result_valid, timeout
  );

  modport slave (
    input  req, done, limit,
    output grant, busy, count, result, result_id, result_valid, timeout
  );
endinterface

// File: rtl/control_ciclos.sv
// control_ciclos: round-robin arbiter for one shared WIDTH-bit cycle counter.
// A requester is granted the counter, the counter is cleared and then runs
// until the owner raises done or the sampled limit is reached; the measured
// count is then reported with a one-cycle result_valid pulse.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high reset
//   bus    control_ciclos_if slave modport (req/done/limit in,
//          grant/busy/count/result/result_id/result_valid/timeout out)
module control_ciclos #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  control_ciclos_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COUNT  = 2'd2,
    REPORT = 2'd3
  } state_t;

  state_t           state_r;
  logic             owner_r;
  logic             last_served_r;
  logic [WIDTH-1:0] limit_q_r;
  logic [1:0]       grant_r;
  logic             busy_r;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] result_r;
  logic             result_id_r;
  logic             result_valid_r;
  logic             timeout_r;
  logic             sel_s;

  // One-hot encoding of a requester index.
  function automatic logic [1:0] onehot_f(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  // Requester picked in IDLE; on a tie the one not served last wins.
  always_comb begin
    sel_s = 1'b0;
    case (bus.req)
      2'b01:   sel_s = 1'b0;
      2'b10:   sel_s = 1'b1;
      2'b11:   sel_s = ~last_served_r;
      default: sel_s = 1'b0;
    endcase
  end

  // Main FSM; every output is a register updated here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= IDLE;
      owner_r        <= 1'b0;
      last_served_r  <= 1'b1;
      limit_q_r      <= {WIDTH{1'b0}};
      grant_r        <= 2'b00;
      busy_r         <= 1'b0;
      count_r        <= {WIDTH{1'b0}};
      result_r       <= {WIDTH{1'b0}};
      result_id_r    <= 1'b0;
      result_valid_r <= 1'b0;
      timeout_r      <= 1'b0;
    end else begin
      result_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.req != 2'b00) begin
            owner_r <= sel_s;
            busy_r  <= 1'b1;
            state_r <= LOAD;
          end else begin
            state_r <= IDLE;
          end
        end
        LOAD: begin
          grant_r   <= onehot_f(owner_r);
          count_r   <= {WIDTH{1'b0}};
          limit_q_r <= bus.limit;
          state_r   <= COUNT;
        end
        COUNT: begin
          // Priority: abort, then done, then limit, then keep counting.
          if (!bus.req[owner_r]) begin
            grant_r <= 2'b00;
            count_r <= {WIDTH{1'b0}};
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else if (bus.done[owner_r]) begin
            result_r       <= count_r;
            timeout_r      <= 1'b0;
            result_id_r    <= owner_r;
            result_valid_r <= 1'b1;
            grant_r        <= 2'b00;
            state_r        <= REPORT;
          end else if (count_r == limit_q_r) begin
            result_r       <= limit_q_r;
            timeout_r      <= 1'b1;
            result_id_r    <= owner_r;
            result_valid_r <= 1'b1;
            grant_r        <= 2'b00;
            state_r        <= REPORT;
          end else begin
            count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
          end
        end
        REPORT: begin
          last_served_r <= owner_r;
          busy_r        <= 1'b0;
          state_r       <= IDLE;
        end
        default: begin
          grant_r <= 2'b00;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.grant        = grant_r;
  assign bus.busy         = busy_r;
  assign bus.count        = count_r;
  assign bus.result       = result_r;
  assign bus.result_id    = result_id_r;
  assign bus.result_valid = result_valid_r;
  assign bus.timeout      = timeout_r;

endmodule

// File: tb/tb_control_ciclos.sv
// tb_control_ciclos: directed self-checking bench for control_ciclos.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_control_ciclos;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  control_ciclos_if #(.WIDTH(8)) bus ();

  control_ciclos #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Checks every output that reset forces.
  task automatic check_reset_values(input string tag);
    check({tag, "_grant"},  32'(bus.grant), 32'd0);
    check({tag, "_busy"},   32'(bus.busy), 32'd0);
    check({tag, "_count"},  32'(bus.count), 32'd0);
    check({tag, "_result"}, 32'(bus.result), 32'd0);
    check({tag, "_rid"},    32'(bus.result_id), 32'd0);
    check({tag, "_valid"},  32'(bus.result_valid), 32'd0);
    check({tag, "_tmo"},    32'(bus.timeout), 32'd0);
  endtask

  // Checks the REPORT cycle outputs.
  task automatic check_report(input string tag, input logic [7:0] res, input logic rid, input logic tmo);
    check({tag, "_valid"},  32'(bus.result_valid), 32'd1);
    check({tag, "_result"}, 32'(bus.result), 32'(res));
    check({tag, "_rid"},    32'(bus.result_id), 32'(rid));
    check({tag, "_tmo"},    32'(bus.timeout), 32'(tmo));
    check({tag, "_grant"},  32'(bus.grant), 32'd0);
    check({tag, "_busy"},   32'(bus.busy), 32'd1);
  endtask

  initial begin
    logic [1:0] exp_grant;
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    bus.req   = 2'b00;
    bus.done  = 2'b00;
    bus.limit = 8'd0;
    #1;
    check_reset_values("rst");
    tick(2);
    reset = 1'b0;
    tick(1);
    check("idle_busy", 32'(bus.busy), 32'd0);

    // Requester 0 alone, done in the 5th COUNT cycle.
    bus.req   = 2'b01;
    bus.limit = 8'd20;
    tick(1);
    check("t1_load_busy", 32'(bus.busy), 32'd1);
    check("t1_load_grant", 32'(bus.grant), 32'd0);
    tick(1);
    check("t1_c0_grant", 32'(bus.grant), 32'd1);
    check("t1_c0_count", 32'(bus.count), 32'd0);
    tick(4);
    check("t1_c4_count", 32'(bus.count), 32'd4);
    check("t1_c4_valid", 32'(bus.result_valid), 32'd0);
    bus.done = 2'b01;
    tick(1);
    check_report("t1_rep", 8'd4, 1'b0, 1'b0);
    bus.done = 2'b00;
    bus.req  = 2'b00;
    tick(1);
    check("t1_post_valid", 32'(bus.result_valid), 32'd0);
    check("t1_post_busy", 32'(bus.busy), 32'd0);
    check("t1_post_count", 32'(bus.count), 32'd4);
    check("t1_post_result", 32'(bus.result), 32'd4);

    // Requester 1 alone, timeout at limit 6; limit changed mid-count.
    bus.req   = 2'b10;
    bus.limit = 8'd6;
    tick(2);
    check("t2_c0_grant", 32'(bus.grant), 32'd2);
    check("t2_c0_count", 32'(bus.count), 32'd0);
    bus.limit = 8'd2;
    tick(3);
    check("t2_c3_count", 32'(bus.count), 32'd3);
    check("t2_c3_busy", 32'(bus.busy), 32'd1);
    check("t2_c3_valid", 32'(bus.result_valid), 32'd0);
    tick(3);
    check("t2_c6_count", 32'(bus.count), 32'd6);
    check("t2_c6_valid", 32'(bus.result_valid), 32'd0);
    tick(1);
    check_report("t2_rep", 8'd6, 1'b1, 1'b1);
    bus.req = 2'b00;
    tick(1);
    check("t2_post_valid", 32'(bus.result_valid), 32'd0);

    // Both requesting: grants alternate starting with requester 0.
    bus.req   = 2'b11;
    bus.limit = 8'd20;
    for (int turn = 0; turn < 4; turn++) begin
      exp_grant = (turn % 2 == 0) ? 2'b01 : 2'b10;
      tick(2);
      check($sformatf("rr%0d_grant", turn), 32'(bus.grant), 32'(exp_grant));
      check($sformatf("rr%0d_count0", turn), 32'(bus.count), 32'd0);
      bus.done = ~exp_grant;
      tick(1);
      check($sformatf("rr%0d_ign_count", turn), 32'(bus.count), 32'd1);
      check($sformatf("rr%0d_ign_valid", turn), 32'(bus.result_valid), 32'd0);
      bus.done = 2'b00;
      tick(2);
      check($sformatf("rr%0d_count3", turn), 32'(bus.count), 32'd3);
      bus.done = exp_grant;
      tick(1);
      check_report($sformatf("rr%0d_rep", turn), 8'd3, exp_grant[1], 1'b0);
      bus.done = 2'b00;
      tick(1);
      check($sformatf("rr%0d_idle_valid", turn), 32'(bus.result_valid), 32'd0);
    end

    // Owner 0 drops its request at count 2; pending requester 1 follows.
    tick(2);
    check("ab_grant", 32'(bus.grant), 32'd1);
    tick(2);
    check("ab_count2", 32'(bus.count), 32'd2);
    bus.req = 2'b10;
    tick(1);
    check("ab_grant0", 32'(bus.grant), 32'd0);
    check("ab_count0", 32'(bus.count), 32'd0);
    check("ab_busy", 32'(bus.busy), 32'd0);
    check("ab_valid", 32'(bus.result_valid), 32'd0);
    check("ab_result", 32'(bus.result), 32'd3);
    check("ab_rid", 32'(bus.result_id), 32'd1);
    tick(1);
    check("ab_next_busy", 32'(bus.busy), 32'd1);
    check("ab_next_valid", 32'(bus.result_valid), 32'd0);
    tick(1);
    check("ab_next_grant", 32'(bus.grant), 32'd2);
    bus.done = 2'b10;
    tick(1);
    check_report("ab_rep", 8'd0, 1'b1, 1'b0);
    bus.done = 2'b00;
    bus.req  = 2'b00;
    tick(1);

    // limit 0 without done: timeout on the first COUNT cycle.
    bus.req   = 2'b01;
    bus.limit = 8'd0;
    tick(2);
    check("l0_count", 32'(bus.count), 32'd0);
    tick(1);
    check_report("l0_rep", 8'd0, 1'b0, 1'b1);
    bus.req = 2'b00;
    tick(1);

    // limit 3 with done on the count==3 cycle: done wins.
    bus.req   = 2'b01;
    bus.limit = 8'd3;
    tick(5);
    check("l3_count", 32'(bus.count), 32'd3);
    bus.done = 2'b01;
    tick(1);
    check_report("l3_rep", 8'd3, 1'b0, 1'b0);
    bus.done = 2'b00;
    bus.req  = 2'b00;
    tick(1);

    // Reset asserted in the middle of COUNT.
    bus.req   = 2'b10;
    bus.limit = 8'd50;
    tick(4);
    check("mr_count2", 32'(bus.count), 32'd2);
    reset = 1'b1;
    #1;
    check_reset_values("mr");
    tick(1);
    check("mr_hold_valid", 32'(bus.result_valid), 32'd0);
    check("mr_hold_grant", 32'(bus.grant), 32'd0);
    reset   = 1'b0;
    bus.req = 2'b00;
    tick(1);
    check("mr_after_valid", 32'(bus.result_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
